// File: rtl/complex_integrate_dump_pkg.sv
// complex_integrate_dump_pkg: default widths shared by the integrate-and-dump slice
package complex_integrate_dump_pkg;
   localparam int DEF_WIDTH_IN  = 16;
   localparam int DEF_ACC_WIDTH = 40;
   localparam int DEF_LEN_WIDTH = 16;
endpackage

// File: rtl/integrate_dump_lane.sv
// integrate_dump_lane: one signed accumulator component with its dump register
module integrate_dump_lane #(
   parameter int WIDTH_IN  = 16,
   parameter int ACC_WIDTH = 40
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        add,
   input  logic                        dump,
   input  logic                        clear,
   input  logic signed [WIDTH_IN-1:0]  sample,
   output logic signed [ACC_WIDTH-1:0] result
);
   logic signed [ACC_WIDTH-1:0] acc, sum;
   assign sum = acc + {{(ACC_WIDTH-WIDTH_IN){sample[WIDTH_IN-1]}}, sample};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         acc    <= '0;
         result <= '0;
      end else begin
         acc <= (clear | dump) ? '0 : add ? sum : acc;
         if (dump) result <= sum;
      end
endmodule

// File: rtl/complex_integrate_dump.sv
// complex_integrate_dump: windowed complex accumulator dumping full-width sums on an AXI-stream
// output; only the window-closing beat can be stalled by a full output register.
module complex_integrate_dump
   import complex_integrate_dump_pkg::*;
#(
   parameter int WIDTH_IN  = DEF_WIDTH_IN,
   parameter int ACC_WIDTH = DEF_ACC_WIDTH,
   parameter int LEN_WIDTH = DEF_LEN_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   clear,
   input  logic [LEN_WIDTH-1:0]   dump_len,
   input  logic [2*WIDTH_IN-1:0]  i_tdata,
   input  logic                   i_tlast,
   input  logic                   i_tvalid,
   output logic                   i_tready,
   output logic [2*ACC_WIDTH-1:0] o_tdata,
   output logic                   o_tlast,
   output logic                   o_tvalid,
   input  logic                   o_tready
);
   localparam logic [LEN_WIDTH-1:0] ONE = LEN_WIDTH'(1);
   logic [LEN_WIDTH-1:0] count, len_r, len_in, eff_len;
   logic is_last, accept, dump;
   logic signed [ACC_WIDTH-1:0] res_i, res_q;
   assign len_in   = (dump_len == '0) ? ONE : dump_len;
   assign eff_len  = (count == '0) ? len_in : len_r;
   assign is_last  = (count == eff_len - ONE) | i_tlast;
   // a beat coinciding with clear is swallowed, so it must never be stalled
   assign i_tready = clear | !is_last | !o_tvalid | o_tready;
   assign accept   = i_tvalid & i_tready & !clear;
   assign dump     = accept & is_last;
   assign o_tdata  = {res_i, res_q};
   always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
         count    <= '0;
         len_r    <= '0;
         o_tvalid <= 1'b0;
         o_tlast  <= 1'b0;
      end else begin
         count <= (clear | dump) ? '0 : accept ? count + ONE : count;
         if (accept && count == '0) len_r <= len_in;
         o_tvalid <= dump | (o_tvalid & !o_tready);
         if (dump) o_tlast <= i_tlast;
      end
   integrate_dump_lane #(.WIDTH_IN(WIDTH_IN), .ACC_WIDTH(ACC_WIDTH)) u_lane_i (
      .clk(clk), .reset_n(reset_n), .add(accept & !is_last), .dump(dump), .clear(clear),
      .sample(i_tdata[2*WIDTH_IN-1:WIDTH_IN]), .result(res_i)
   );
   integrate_dump_lane #(.WIDTH_IN(WIDTH_IN), .ACC_WIDTH(ACC_WIDTH)) u_lane_q (
      .clk(clk), .reset_n(reset_n), .add(accept & !is_last), .dump(dump), .clear(clear),
      .sample(i_tdata[WIDTH_IN-1:0]), .result(res_q)
   );
endmodule

// File: tb/tb_complex_integrate_dump.sv
// tb_complex_integrate_dump: directed scenarios with hand-computed window sums
module tb_complex_integrate_dump;
   logic        clk = 1'b0;
   logic        reset_n, clear, i_tlast, i_tvalid, o_tready;
   logic [15:0] dump_len;
   logic [31:0] i_tdata;
   logic        i_tready, o_tlast, o_tvalid;
   logic [79:0] o_tdata;
   int          pass = 0, total = 0;

   complex_integrate_dump dut (
      .clk(clk), .reset_n(reset_n), .clear(clear), .dump_len(dump_len),
      .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
      .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready)
   );

   always #5 clk = ~clk;

   function automatic logic [79:0] pk(input logic signed [39:0] a, input logic signed [39:0] b);
      return {a, b};
   endfunction

   task automatic beat(input logic [15:0] i, input logic [15:0] q, input logic last);
      int n = 0;
      i_tdata = {i, q};
      i_tlast = last;
      i_tvalid = 1'b1;
      #1;
      while (!i_tready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) begin
         total++;
         $display("FAIL beat_timeout: i_tready=%b required 1 within 50 cycles", i_tready);
      end
      @(posedge clk);
      @(negedge clk);
      i_tvalid = 1'b0;
      i_tlast = 1'b0;
   endtask

   task automatic test_reset;
      reset_n = 1'b0; clear = 1'b0; i_tlast = 1'b0; i_tvalid = 1'b0;
      o_tready = 1'b1; dump_len = '0; i_tdata = '0;
      @(negedge clk); @(negedge clk);
      total++; if (o_tvalid !== 1'b0) $display("FAIL reset_tvalid: got %b want 0", o_tvalid); else pass++;
      total++; if (o_tdata !== '0) $display("FAIL reset_tdata: got %h want 0", o_tdata); else pass++;
      total++; if (o_tlast !== 1'b0) $display("FAIL reset_tlast: got %b want 0", o_tlast); else pass++;
      total++; if (i_tready !== 1'b1) $display("FAIL reset_tready: got %b want 1", i_tready); else pass++;
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_basic;
      dump_len = 16'd4;
      o_tready = 1'b1;
      for (int k = 0; k < 3; k++) beat(16'd1, 16'hFFFF, 1'b0);
      total++; if (o_tvalid !== 1'b0) $display("FAIL basic_early: o_tvalid=%b want 0", o_tvalid); else pass++;
      beat(16'd1, 16'hFFFF, 1'b0);
      total++; if (o_tvalid !== 1'b1) $display("FAIL basic_valid: got %b want 1", o_tvalid); else pass++;
      total++; if (o_tdata !== pk(4, -4)) $display("FAIL basic_data: got %h want %h", o_tdata, pk(4, -4)); else pass++;
      total++; if (o_tlast !== 1'b0) $display("FAIL basic_tlast: got %b want 0", o_tlast); else pass++;
      @(negedge clk);
      total++; if (o_tvalid !== 1'b0) $display("FAIL basic_drain: o_tvalid=%b want 0", o_tvalid); else pass++;
   endtask

   task automatic test_backpressure;
      dump_len = 16'd2;
      o_tready = 1'b0;
      beat(16'd1, -16'sd1, 1'b0);
      beat(16'd2, -16'sd2, 1'b0);
      total++; if (o_tdata !== pk(3, -3) || o_tvalid !== 1'b1) $display("FAIL bp_first: got %h v=%b want %h v=1", o_tdata, o_tvalid, pk(3, -3)); else pass++;
      beat(16'd3, -16'sd3, 1'b0);
      i_tdata = {16'd4, -16'sd4};
      i_tvalid = 1'b1;
      #1;
      total++; if (i_tready !== 1'b0) $display("FAIL bp_stall: i_tready=%b want 0", i_tready); else pass++;
      @(negedge clk); @(negedge clk);
      total++; if (i_tready !== 1'b0 || o_tdata !== pk(3, -3)) $display("FAIL bp_hold: rdy=%b data=%h want 0 %h", i_tready, o_tdata, pk(3, -3)); else pass++;
      o_tready = 1'b1;
      #1;
      total++; if (i_tready !== 1'b1) $display("FAIL bp_release: i_tready=%b want 1", i_tready); else pass++;
      @(posedge clk); @(negedge clk);
      i_tvalid = 1'b0;
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(7, -7)) $display("FAIL bp_second: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(7, -7)); else pass++;
      @(negedge clk);
      total++; if (o_tvalid !== 1'b0) $display("FAIL bp_drain: o_tvalid=%b want 0", o_tvalid); else pass++;
   endtask

   task automatic test_early_last;
      dump_len = 16'd8;
      beat(16'd10, 16'd0, 1'b0);
      beat(16'd20, 16'd0, 1'b0);
      beat(16'd30, 16'd0, 1'b1);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(60, 0)) $display("FAIL tlast_data: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(60, 0)); else pass++;
      total++; if (o_tlast !== 1'b1) $display("FAIL tlast_flag: got %b want 1", o_tlast); else pass++;
      dump_len = 16'd2;
      beat(16'd1, 16'd1, 1'b0);
      beat(16'd1, 16'd1, 1'b0);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(2, 2) || o_tlast !== 1'b0) $display("FAIL tlast_restart: v=%b data=%h last=%b want 1 %h 0", o_tvalid, o_tdata, o_tlast, pk(2, 2)); else pass++;
   endtask

   task automatic test_len_change;
      dump_len = 16'd4;
      beat(16'd1, 16'd0, 1'b0);
      dump_len = 16'd2;
      beat(16'd1, 16'd0, 1'b0);
      beat(16'd1, 16'd0, 1'b0);
      total++; if (o_tvalid !== 1'b0) $display("FAIL len_hold: o_tvalid=%b want 0", o_tvalid); else pass++;
      beat(16'd1, 16'd0, 1'b0);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(4, 0)) $display("FAIL len_old: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(4, 0)); else pass++;
      beat(16'd1, 16'd0, 1'b0);
      beat(16'd1, 16'd0, 1'b0);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(2, 0)) $display("FAIL len_new: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(2, 0)); else pass++;
   endtask

   task automatic test_extremes;
      dump_len = 16'd256;
      for (int k = 0; k < 256; k++) beat(16'h7FFF, 16'h8000, 1'b0);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(40'sh7FFF00, -40'sh800000)) $display("FAIL extremes: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(40'sh7FFF00, -40'sh800000)); else pass++;
      @(negedge clk);
   endtask

   task automatic test_reset_clear;
      dump_len = 16'd4;
      beat(16'd1, 16'd1, 1'b0);
      beat(16'd1, 16'd1, 1'b0);
      reset_n = 1'b0;
      #1;
      total++; if (o_tvalid !== 1'b0 || o_tdata !== '0 || o_tlast !== 1'b0) $display("FAIL mid_reset: v=%b data=%h last=%b want 0 0 0", o_tvalid, o_tdata, o_tlast); else pass++;
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 4; k++) beat(16'd1, 16'd1, 1'b0);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(4, 4)) $display("FAIL after_reset: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(4, 4)); else pass++;
      beat(16'd1, 16'd1, 1'b0);
      beat(16'd1, 16'd1, 1'b0);
      clear = 1'b1;
      i_tdata = {16'd100, 16'd100};
      i_tlast = 1'b1;
      i_tvalid = 1'b1;
      #1;
      total++; if (i_tready !== 1'b1) $display("FAIL clear_ready: i_tready=%b want 1", i_tready); else pass++;
      @(posedge clk); @(negedge clk);
      clear = 1'b0; i_tvalid = 1'b0; i_tlast = 1'b0;
      total++; if (o_tvalid !== 1'b0) $display("FAIL clear_drop: o_tvalid=%b want 0", o_tvalid); else pass++;
      for (int k = 0; k < 3; k++) beat(16'd1, 16'd1, 1'b0);
      total++; if (o_tvalid !== 1'b0) $display("FAIL clear_early: o_tvalid=%b want 0", o_tvalid); else pass++;
      beat(16'd1, 16'd1, 1'b0);
      total++; if (o_tvalid !== 1'b1 || o_tdata !== pk(4, 4)) $display("FAIL after_clear: v=%b data=%h want 1 %h", o_tvalid, o_tdata, pk(4, 4)); else pass++;
   endtask

   initial begin
      test_reset;
      test_basic;
      test_backpressure;
      test_early_last;
      test_len_change;
      test_extremes;
      test_reset_clear;
      $display("%0d/%0d checks passed", pass, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
